// File: rtl/memory_responder.sv
// memory_responder: word-addressed memory slave with a programmable number of
// wait states, a one-cycle ACK pulse and a HOLD state that waits for the
// request to drop before accepting the next transaction.
module memory_responder #(
    parameter int unsigned DATAWIDTH_BUS  = 32,
    parameter int unsigned MEM_ADDR_WIDTH = 8,
    parameter int unsigned WAIT_CYCLES    = 2
) (
    input  logic                     MEMORY_RESPONDER_CLOCK_50,
    input  logic                     MEMORY_RESPONDER_ResetInHigh_In,
    input  logic [DATAWIDTH_BUS-1:0] MEMORY_RESPONDER_A_InBus,
    input  logic [DATAWIDTH_BUS-1:0] MEMORY_RESPONDER_B_InBus,
    input  logic                     MEMORY_RESPONDER_RD_In,
    input  logic                     MEMORY_RESPONDER_WRMain_In,
    output logic                     MEMORY_RESPONDER_ACK_Out,
    output logic [DATAWIDTH_BUS-1:0] MEMORY_RESPONDER_Data_OutBus,
    output logic                     MEMORY_RESPONDER_Busy_Out,
    output logic                     MEMORY_RESPONDER_Err_Out
);

    localparam int unsigned DEPTH   = 1 << MEM_ADDR_WIDTH;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned IDX_LSB = 2;
    localparam int unsigned IDX_MSB = MEM_ADDR_WIDTH + 1;
    localparam int unsigned OOR_LSB = MEM_ADDR_WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2,
        HOLD = 2'd3
    } state_t;

    logic clk;
    logic rst;
    logic rd_in;
    logic wr_in;
    logic req_c;

    assign clk   = MEMORY_RESPONDER_CLOCK_50;
    assign rst   = MEMORY_RESPONDER_ResetInHigh_In;
    assign rd_in = MEMORY_RESPONDER_RD_In;
    assign wr_in = MEMORY_RESPONDER_WRMain_In;
    assign req_c = rd_in | wr_in;

    // Storage starts cleared and is never touched by reset.
    logic [DATAWIDTH_BUS-1:0] mem [DEPTH] = '{default: '0};

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [DATAWIDTH_BUS-1:0] addr_q, wdata_q;
    logic                     rd_q, conf_q;
    logic                     ack_q, busy_q, err_q;
    logic [DATAWIDTH_BUS-1:0] data_q, data_d;
    logic                     latch_c;
    logic                     access_c;

    // Operands of the access: straight from the bus when completing in the
    // sampling cycle (zero wait states), otherwise the latched copy.
    logic [DATAWIDTH_BUS-1:0]  op_addr_c, op_wdata_c;
    logic                      op_rd_c, op_conf_c, op_oor_c, op_err_c;
    logic [MEM_ADDR_WIDTH-1:0] op_idx_c;
    logic                      unused_addr_bits_c;

    // Select live or latched transaction operands.
    always_comb begin
        if (state_q == IDLE) begin
            op_addr_c  = MEMORY_RESPONDER_A_InBus;
            op_wdata_c = MEMORY_RESPONDER_B_InBus;
            op_rd_c    = rd_in;
            op_conf_c  = rd_in & wr_in;
        end else begin
            op_addr_c  = addr_q;
            op_wdata_c = wdata_q;
            op_rd_c    = rd_q;
            op_conf_c  = conf_q;
        end
        op_idx_c = op_addr_c[IDX_MSB:IDX_LSB];
        op_oor_c = (op_addr_c >> OOR_LSB) != '0;
        op_err_c = op_oor_c | op_conf_c;
    end

    // Byte-lane bits of the address never select anything.
    assign unused_addr_bits_c = ^op_addr_c[IDX_LSB-1:0];

    // Next-state, wait counter and access strobe.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        latch_c  = 1'b0;
        access_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_c) begin
                    latch_c = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d  = ACK;
                        access_c = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d  = ACK;
                    access_c = 1'b1;
                    cnt_d    = '0;
                end
            end
            ACK: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (!req_c) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read data register: reloaded only by a completing read.
    always_comb begin
        data_d = data_q;
        if (access_c && op_rd_c) begin
            data_d = op_oor_c ? '0 : mem[op_idx_c];
        end
    end

    // State, latched request and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            conf_q  <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch_c) begin
                addr_q  <= MEMORY_RESPONDER_A_InBus;
                wdata_q <= MEMORY_RESPONDER_B_InBus;
                rd_q    <= rd_in;
                conf_q  <= rd_in & wr_in;
            end
            ack_q  <= access_c;
            busy_q <= (state_d != IDLE);
            err_q  <= access_c & op_err_c;
            data_q <= data_d;
        end
    end

    // Memory write on the edge that enters ACK; blocked by reset.
    always_ff @(posedge clk) begin
        if (!rst && access_c && !op_rd_c && !op_oor_c) begin
            mem[op_idx_c] <= op_wdata_c;
        end
    end

    assign MEMORY_RESPONDER_ACK_Out     = ack_q;
    assign MEMORY_RESPONDER_Busy_Out    = busy_q;
    assign MEMORY_RESPONDER_Err_Out     = err_q;
    assign MEMORY_RESPONDER_Data_OutBus = data_q;

endmodule
